adc_capture: RTL and testbench

- Triggered ADC sample capture buffer; sits directly downstream of the adc trigger stage.
- Continuously writes 8-bit ADC samples into a circular RAM while armed.
- Drives sq_active to the trigger stage and consumes its sq_trigger pulse.
- Stops after a programmed number of post-trigger samples; the host reads the window (pre-trigger, trigger, post-trigger samples) over the 8-bit wishbone slave.

---
 rtl/adc_capture.sv | 276 +++++++++++++++++++++++++++
 tb/tb_adc_capture.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// adc_capture: triggered capture of an 8-bit ADC stream into a circular RAM.
// The buffer runs while armed. After a trigger it collects a programmed number
// of further samples, then freezes. The host reads the window back over an
// 8-bit wishbone slave: the pre-trigger samples, the trigger sample and the
// post-trigger samples, oldest first.
module adc_capture #(
  parameter int DEPTH_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  adc,
  input  logic        sq_trigger,
  output logic        sq_active,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o
);

  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << DEPTH_BITS;

  typedef logic [DEPTH_BITS-1:0] ptr_t;
  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t PTR_ZERO = ptr_t'(0);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PRE_L  = 3'd1;
  localparam logic [2:0] A_PRE_H  = 3'd2;
  localparam logic [2:0] A_POST_L = 3'd3;
  localparam logic [2:0] A_POST_H = 3'd4;
  localparam logic [2:0] A_DATA   = 3'd5;
  localparam logic [2:0] A_TRIG_L = 3'd6;
  localparam logic [2:0] A_TRIG_H = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Capture bookkeeping.
  ptr_t r_wr_ptr;
  ptr_t r_rd_ptr;
  ptr_t r_trig_pos;
  ptr_t r_pre_cnt;
  ptr_t r_post_cnt;
  ptr_t r_pre;
  ptr_t r_post;
  logic r_sq_active;

  // Wishbone side.
  logic              r_ack;
  logic              r_pop;
  logic              r_rd_sel;
  logic [DATA_W-1:0] r_dat;
  logic [DATA_W-1:0] r_ram_q;

  // Sample store; the contents survive reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_req;
  logic              w_wr;
  logic              w_rd;
  logic [2:0]        w_addr;
  logic              w_cfg_ok;
  logic              w_arm;
  logic              w_abort;
  logic              w_capture;
  logic              w_trig;
  logic              w_pop_req;
  logic              w_done_entry;
  ptr_t              w_trig_ref;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_unused;

  // Zero-extend a pointer-width value and return the requested byte of it.
  function automatic logic [7:0] get_byte(input ptr_t v, input logic hi);
    logic [15:0] w;
    w = 16'(v);
    return hi ? w[15:8] : w[7:0];
  endfunction

  // Replace one byte of a pointer-width value; bits beyond DEPTH_BITS are dropped.
  function automatic ptr_t put_byte(input ptr_t cur, input logic hi,
                                    input logic [7:0] d);
    logic [15:0] w;
    w = 16'(cur);
    if (hi) begin
      w = {d, w[7:0]};
    end else begin
      w = {w[15:8], d};
    end
    return ptr_t'(w);
  endfunction

  // A new request exists only when no ack is pending. This spaces acks apart
  // even if the master holds strobe high.
  assign w_req  = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr   = w_req & wb_we_i;
  assign w_rd   = w_req & ~wb_we_i;
  assign w_addr = wb_adr_i[2:0];

  assign w_cfg_ok  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_capture = (r_state == S_FILL) || (r_state == S_WAIT) ||
                     (r_state == S_POST);

  assign w_arm   = w_wr && (w_addr == A_CTRL) && wb_dat_i[0] && w_cfg_ok;
  assign w_abort = w_wr && (w_addr == A_CTRL) && !wb_dat_i[0];

  // An abort in the same cycle discards a trigger.
  assign w_trig = (r_state == S_WAIT) && sq_trigger && !w_abort;

  assign w_pop_req = w_rd && (w_addr == A_DATA) && (r_state == S_DONE);

  assign w_done_entry = (w_state_nxt == S_DONE) && (r_state != S_DONE);
  // Going straight from WAIT to DONE (post = 0) means trig_pos is only being
  // loaded this cycle. In that case the window is anchored on the live write
  // pointer.
  assign w_trig_ref = (r_state == S_WAIT) ? r_wr_ptr : r_trig_pos;

  assign w_status = {5'b0,
                     (r_state == S_DONE),
                     (r_state == S_POST) || (r_state == S_DONE),
                     w_capture};

  assign w_unused = ^wb_adr_i[15:3];

  // Next-state logic. Arm and abort take priority over the capture progress.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_IDLE;
      S_FILL: begin
        if ((r_pre_cnt + PTR_ONE) == r_pre) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sq_trigger) begin
          w_state_nxt = (r_post == PTR_ZERO) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if ((r_post_cnt + PTR_ONE) == r_post) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_arm) begin
      w_state_nxt = (r_pre == PTR_ZERO) ? S_WAIT : S_FILL;
    end
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  // State register; sq_active is registered so it is high exactly in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sq_active <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sq_active <= (w_state_nxt == S_WAIT);
    end
  end

  // Pointers, counters and the trigger position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_trig_pos <= '0;
      r_pre_cnt  <= '0;
      r_post_cnt <= '0;
    end else begin
      if (w_arm) begin
        r_wr_ptr  <= '0;
        r_pre_cnt <= '0;
      end else if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (r_state == S_FILL) begin
          r_pre_cnt <= r_pre_cnt + PTR_ONE;
        end
      end

      if (w_trig) begin
        r_trig_pos <= r_wr_ptr;
        r_post_cnt <= '0;
      end else if (r_state == S_POST) begin
        r_post_cnt <= r_post_cnt + PTR_ONE;
      end

      if (w_done_entry) begin
        r_rd_ptr <= w_trig_ref - r_pre;
      end else if (r_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Window configuration. It is only writable while no capture is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_post <= '0;
    end else if (w_wr && w_cfg_ok) begin
      case (w_addr)
        A_PRE_L:  r_pre  <= put_byte(r_pre,  1'b0, wb_dat_i);
        A_PRE_H:  r_pre  <= put_byte(r_pre,  1'b1, wb_dat_i);
        A_POST_L: r_post <= put_byte(r_post, 1'b0, wb_dat_i);
        A_POST_H: r_post <= put_byte(r_post, 1'b1, wb_dat_i);
        default:  ;
      endcase
    end
  end

  // Register read mux. The sample port is served from the RAM output register.
  always_comb begin
    w_rd_data = '0;
    case (w_addr)
      A_CTRL:   w_rd_data = w_status;
      A_PRE_L:  w_rd_data = get_byte(r_pre,      1'b0);
      A_PRE_H:  w_rd_data = get_byte(r_pre,      1'b1);
      A_POST_L: w_rd_data = get_byte(r_post,     1'b0);
      A_POST_H: w_rd_data = get_byte(r_post,     1'b1);
      A_TRIG_L: w_rd_data = get_byte(r_trig_pos, 1'b0);
      A_TRIG_H: w_rd_data = get_byte(r_trig_pos, 1'b1);
      default:  w_rd_data = '0;
    endcase
  end

  // Wishbone ack and read-data registers. A sample pop advances rd_ptr in the ack cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack    <= 1'b0;
      r_pop    <= 1'b0;
      r_rd_sel <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_ack <= w_req;
      r_pop <= w_pop_req;
      if (w_req) begin
        r_rd_sel <= w_pop_req;
        r_dat    <= w_rd ? w_rd_data : '0;
      end
    end
  end

  // Sample RAM: one write port fed while capturing, one registered read port used in DONE.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= adc;
    end
    if (w_pop_req) begin
      r_ram_q <= r_mem[r_rd_ptr];
    end
  end

  assign wb_dat_o  = r_rd_sel ? r_ram_q : r_dat;
  assign wb_ack_o  = r_ack;
  assign sq_active = r_sq_active;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture with a 16-entry buffer. The ADC input is a
// ramp that steps once per clock, so every expected sample is a known value.
module tb_adc_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  adc;
  logic        sq_trigger;
  logic        sq_active;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [15:0] wb_adr_i;
  logic [7:0]  wb_dat_i;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_capture #(.DEPTH_BITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc        (adc),
    .sq_trigger (sq_trigger),
    .sq_active  (sq_active),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o)
  );

  // One clock: the edge samples the current adc, then the ramp advances.
  task automatic step();
    @(posedge clk);
    #1;
    adc = adc + 8'd1;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = {13'b0, a}; wb_dat_i = d;
    step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    step();
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = {13'b0, a};
    step();
    d = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0; adc = 8'd0; sq_trigger = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0;
    step(); step();
    checks++; if (sq_active !== 1'b0) begin failures++; $display("FAIL rst_sq_active got=%b exp=0", sq_active); end
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", wb_ack_o); end
    checks++; if (wb_dat_o !== 8'h00) begin failures++; $display("FAIL rst_dat got=%h exp=00", wb_dat_o); end
    rst_n = 1'b1;
    step();
    wb_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_status got=%h exp=00", d); end
    wb_read(3'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_pre got=%h exp=00", d); end
    wb_read(3'd6, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_trig_pos got=%h exp=00", d); end
  endtask

  task automatic test_handshake();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'd0;
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL hs_ack_before got=%b exp=0", wb_ack_o); end
    step();
    checks++; if (wb_ack_o !== 1'b1) begin failures++; $display("FAIL hs_ack_first got=%b exp=1", wb_ack_o); end
    step();
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL hs_ack_gap got=%b exp=0", wb_ack_o); end
    step();
    checks++; if (wb_ack_o !== 1'b1) begin failures++; $display("FAIL hs_ack_second got=%b exp=1", wb_ack_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL hs_ack_release got=%b exp=0", wb_ack_o); end
  endtask

  // pre=3, post=4, first captured sample is 10, trigger at 20.
  task automatic test_capture_ramp();
    logic [7:0] d;
    int n;
    wb_write(3'd1, 8'd3); wb_write(3'd2, 8'd0);
    wb_write(3'd3, 8'd4); wb_write(3'd4, 8'd0);
    adc = 8'd9;
    wb_write(3'd0, 8'd1);
    checks++; if (sq_active !== 1'b0) begin failures++; $display("FAIL ramp_active_fill got=%b exp=0", sq_active); end
    n = 0;
    while (adc != 8'd20 && n < 40) begin step(); n++; end
    checks++; if (adc !== 8'd20) begin failures++; $display("FAIL ramp_reach_trigger got=%0d exp=20", adc); end
    checks++; if (sq_active !== 1'b1) begin failures++; $display("FAIL ramp_active_wait got=%b exp=1", sq_active); end
    sq_trigger = 1'b1; step(); sq_trigger = 1'b0;
    step(); step(); step(); step();
    checks++; if (sq_active !== 1'b0) begin failures++; $display("FAIL ramp_active_done got=%b exp=0", sq_active); end
    wb_read(3'd0, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL ramp_status got=%h exp=06", d); end
    wb_read(3'd6, d);
    checks++; if (d !== 8'd10) begin failures++; $display("FAIL ramp_trig_pos got=%0d exp=10", d); end
    wb_read(3'd7, d);
    checks++; if (d !== 8'd0) begin failures++; $display("FAIL ramp_trig_pos_hi got=%0d exp=0", d); end
    for (int i = 0; i < 8; i++) begin
      wb_read(3'd5, d);
      checks++; if (d !== 8'(17 + i)) begin failures++; $display("FAIL ramp_sample%0d got=%0d exp=%0d", i, d, 17 + i); end
    end
    wb_read(3'd5, d);
    for (int i = 0; i < 7; i++) begin
      wb_read(3'd5, d);
      checks++; if (d !== 8'(10 + i)) begin failures++; $display("FAIL ramp_wrap%0d got=%0d exp=%0d", i, d, 10 + i); end
    end
    wb_read(3'd5, d);
    checks++; if (d !== 8'd17) begin failures++; $display("FAIL ramp_wrap_full got=%0d exp=17", d); end
  endtask

  // pre=3, post=2; a trigger during FILL is ignored.
  task automatic test_fill_trigger_ignored();
    logic [7:0] d;
    int n;
    adc = 8'd40;
    wb_write(3'd3, 8'd2);
    wb_write(3'd0, 8'd1);
    sq_trigger = 1'b1; step(); sq_trigger = 1'b0;
    checks++; if (sq_active !== 1'b0) begin failures++; $display("FAIL fill_active_after_trig got=%b exp=0", sq_active); end
    step();
    checks++; if (sq_active !== 1'b1) begin failures++; $display("FAIL fill_active_wait got=%b exp=1", sq_active); end
    wb_read(3'd0, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL fill_status_wait got=%h exp=01", d); end
    n = 0;
    while (adc != 8'd80 && n < 60) begin step(); n++; end
    sq_trigger = 1'b1; step(); sq_trigger = 1'b0;
    step(); step();
    wb_read(3'd0, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL fill_status_done got=%h exp=06", d); end
    wb_read(3'd6, d);
    checks++; if (d !== 8'd5) begin failures++; $display("FAIL fill_trig_pos got=%0d exp=5", d); end
    for (int i = 0; i < 6; i++) begin
      wb_read(3'd5, d);
      checks++; if (d !== 8'(77 + i)) begin failures++; $display("FAIL fill_sample%0d got=%0d exp=%0d", i, d, 77 + i); end
    end
  endtask

  // pre=0, post=0: the trigger in the first WAIT cycle completes the capture.
  task automatic test_pre0_post0();
    logic [7:0] d;
    wb_write(3'd1, 8'd0);
    wb_write(3'd3, 8'd0);
    adc = 8'h50;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 16'd0; wb_dat_i = 8'd1;
    step();
    checks++; if (sq_active !== 1'b1) begin failures++; $display("FAIL p0_active got=%b exp=1", sq_active); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    sq_trigger = 1'b1; step(); sq_trigger = 1'b0;
    checks++; if (sq_active !== 1'b0) begin failures++; $display("FAIL p0_active_done got=%b exp=0", sq_active); end
    wb_read(3'd0, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL p0_status got=%h exp=06", d); end
    wb_read(3'd6, d);
    checks++; if (d !== 8'd0) begin failures++; $display("FAIL p0_trig_pos got=%0d exp=0", d); end
    wb_read(3'd5, d);
    checks++; if (d !== 8'h51) begin failures++; $display("FAIL p0_sample got=%h exp=51", d); end
  endtask

  // pre=5, post=2, with many buffer wraps before the trigger at 67.
  task automatic test_long_wait();
    logic [7:0] d;
    int n;
    wb_write(3'd1, 8'd5);
    wb_write(3'd3, 8'd2);
    adc = 8'd0;
    wb_write(3'd0, 8'd1);
    n = 0;
    while (adc != 8'd67 && n < 100) begin step(); n++; end
    checks++; if (sq_active !== 1'b1) begin failures++; $display("FAIL long_active got=%b exp=1", sq_active); end
    sq_trigger = 1'b1; step(); sq_trigger = 1'b0;
    step(); step();
    wb_read(3'd6, d);
    checks++; if (d !== 8'd2) begin failures++; $display("FAIL long_trig_pos got=%0d exp=2", d); end
    for (int i = 0; i < 8; i++) begin
      wb_read(3'd5, d);
      checks++; if (d !== 8'(62 + i)) begin failures++; $display("FAIL long_sample%0d got=%0d exp=%0d", i, d, 62 + i); end
    end
  endtask

  // An abort coincident with a trigger wins; writes while armed are ignored.
  task automatic test_abort();
    logic [7:0] d;
    wb_write(3'd1, 8'd2);
    wb_write(3'd3, 8'd3);
    wb_write(3'd0, 8'd1);
    step(); step(); step();
    checks++; if (sq_active !== 1'b1) begin failures++; $display("FAIL abort_active_wait got=%b exp=1", sq_active); end
    wb_write(3'd1, 8'd9);
    wb_read(3'd1, d);
    checks++; if (d !== 8'd2) begin failures++; $display("FAIL abort_pre_locked got=%0d exp=2", d); end
    wb_write(3'd0, 8'd1);
    wb_read(3'd0, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL abort_rearm_ignored got=%h exp=01", d); end
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 16'd0; wb_dat_i = 8'd0;
    sq_trigger = 1'b1; step(); sq_trigger = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    checks++; if (sq_active !== 1'b0) begin failures++; $display("FAIL abort_active got=%b exp=0", sq_active); end
    step();
    wb_read(3'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL abort_status got=%h exp=00", d); end
    wb_read(3'd5, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL abort_sample got=%h exp=00", d); end
    wb_write(3'd1, 8'd7);
    wb_read(3'd1, d);
    checks++; if (d !== 8'd7) begin failures++; $display("FAIL abort_pre_write got=%0d exp=7", d); end
    wb_write(3'd3, 8'd9);
    wb_read(3'd3, d);
    checks++; if (d !== 8'd9) begin failures++; $display("FAIL abort_post_write got=%0d exp=9", d); end
  endtask

  // Asynchronous reset during POST, with a read ack in flight.
  task automatic test_reset_in_post();
    logic [7:0] d;
    wb_write(3'd1, 8'd1);
    wb_write(3'd3, 8'd10);
    wb_write(3'd0, 8'd1);
    step(); step();
    sq_trigger = 1'b1; step(); sq_trigger = 1'b0;
    step();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'd0;
    step();
    checks++; if (wb_ack_o !== 1'b1) begin failures++; $display("FAIL post_ack got=%b exp=1", wb_ack_o); end
    checks++; if (wb_dat_o !== 8'h03) begin failures++; $display("FAIL post_status got=%h exp=03", wb_dat_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL arst_ack got=%b exp=0", wb_ack_o); end
    checks++; if (wb_dat_o !== 8'h00) begin failures++; $display("FAIL arst_dat got=%h exp=00", wb_dat_o); end
    checks++; if (sq_active !== 1'b0) begin failures++; $display("FAIL arst_active got=%b exp=0", sq_active); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'd0;
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL arst_ack_idle got=%b exp=0", wb_ack_o); end
    step();
    checks++; if (wb_ack_o !== 1'b1) begin failures++; $display("FAIL arst_ack_resume got=%b exp=1", wb_ack_o); end
    checks++; if (wb_dat_o !== 8'h00) begin failures++; $display("FAIL arst_status got=%h exp=00", wb_dat_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
    wb_read(3'd1, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL arst_pre got=%h exp=00", d); end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_capture_ramp();
    test_fill_trigger_ignored();
    test_pre0_post0();
    test_long_wait();
    test_abort();
    test_reset_in_post();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
